alu: RTL and testbench
======================

ALU -- requirements
Module: alu

Interface
REQ-001 Parameter DATA_W, default 8, operand/result width; all values below are stated for DATA_W=8.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 alu_op  input  4  operation select.
REQ-005 operand_a  input  DATA_W  operand A.
REQ-006 operand_b  input  DATA_W  operand B.
REQ-007 alu_result  output  DATA_W  registered result.
REQ-008 zero_flag  output  1  registered; 1 when the registered alu_result is 0x00.
REQ-009 carry_flag  output  1  registered carry / borrow / shifted-out bit.
REQ-010 overflow_flag  output  1  registered two's-complement signed overflow.

Function
REQ-011 Inputs SHALL be sampled on each rising clk edge with rst=0; outputs SHALL update on that edge (latency 1 cycle) and hold until the next edge.
REQ-012 No handshake; a new operation is accepted every cycle (throughput 1/cycle).
REQ-013 0000 ADD: result = (A+B) mod 256; carry = bit 8 of the 9-bit sum; overflow = A[7]==B[7] and result[7]!=A[7].
REQ-014 0001 SUB: result = (A-B) mod 256; carry = 1 when A<B unsigned (borrow); overflow = A[7]!=B[7] and result[7]!=A[7].
REQ-015 0010 AND, 0011 OR, 0100 XOR: bitwise A op B; carry=0, overflow=0.
REQ-016 0101 NOT: result = ~A, B ignored; carry=0, overflow=0.
REQ-017 0110 SHL: result = {A[6:0],0}; carry = A[7]; overflow=0; B ignored.
REQ-018 0111 SHR (logical): result = {0,A[7:1]}; carry = A[0]; overflow=0; B ignored.
REQ-019 1000 CMP: result, carry and overflow identical to SUB (A-B); zero_flag=1 iff A==B.
REQ-020 Any other opcode (1001-1111): result=0x00, carry=0, overflow=0, zero_flag=1.
REQ-021 For every non-reset cycle, zero_flag SHALL equal (alu_result==0), computed from the new result in the same edge.
REQ-022 Wrap-around: ADD/SUB results are modulo 2^DATA_W; no saturation.

Reset
REQ-023 On a rising edge with rst=1: alu_result=0x00, zero_flag=0, carry_flag=0, overflow_flag=0, regardless of alu_op/operands.
REQ-024 Reset asserted mid-stream SHALL discard the operation sampled on that edge; the first edge with rst=0 produces a normal result.
REQ-025 rst SHALL have no effect between clock edges.

Structure
REQ-026 Opcode constants (OP_ADD..OP_CMP) SHALL live in shared package alu_pkg, also used by the decoder.
REQ-027 Combinational datapath SHALL be a sub-module alu_core (ops and next-flags); alu holds only the output registers and reset.
REQ-028 ADD/SUB/CMP SHALL share one DATA_W+1 adder (B inverted, carry-in 1 for subtract).

Verification
REQ-029 ADD 0x05+0x0A -> 0x0F, Z0 C0 V0; ADD 0xFF+0x01 -> 0x00, Z1 C1 V0; ADD 0x7F+0x01 -> 0x80, Z0 C0 V1.
REQ-030 SUB 0x0A-0x05 -> 0x05, C0 V0; SUB 0x05-0x0A -> 0xFB, C1 V0; SUB 0x80-0x01 -> 0x7F, C0 V1.
REQ-031 A=0x0F,B=0x3C: AND -> 0x0C, OR -> 0x3F, XOR -> 0x33; NOT 0x55 -> 0xAA; all C0 V0.
REQ-032 SHL 0x0A -> 0x14 C0; SHL 0x81 -> 0x02 C1; SHR 0xA0 -> 0x50 C0; SHR 0x01 -> 0x00 Z1 C1.
REQ-033 CMP 0x12,0x12 -> Z1 C0; CMP 0x12,0x34 -> Z0 C1 result 0xDE; op 1111 A=0xAA B=0xBB -> 0x00 Z1 C0 V0.
REQ-034 Timing/reset: outputs change only one edge after input change; rst=1 on one edge during back-to-back ADDs -> all outputs 0 that cycle, next edge normal result.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encodings and flag bundle for the ALU datapath and its register stage.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_AND = 4'b0010,
    OP_OR  = 4'b0011,
    OP_XOR = 4'b0100,
    OP_NOT = 4'b0101,
    OP_SHL = 4'b0110,
    OP_SHR = 4'b0111,
    OP_CMP = 4'b1000
  } alu_op_e;

  typedef struct packed {
    logic zero;
    logic carry;
    logic overflow;
  } alu_flags_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: operation decode, shared add/subtract adder and next-flag logic.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  output logic [DATA_W-1:0] result,
  output alu_flags_t        flags
);

  logic              subtract;
  logic [DATA_W-1:0] b_eff;
  logic [DATA_W:0]   sum;
  logic              add_ovf;

  // One adder serves ADD/SUB/CMP: subtract is A + ~B + 1, so borrow is the inverted carry-out.
  always_comb begin
    subtract = (alu_op == OP_SUB) || (alu_op == OP_CMP);
    b_eff    = subtract ? ~operand_b : operand_b;
    sum      = {1'b0, operand_a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, subtract};
    add_ovf  = (operand_a[DATA_W-1] == b_eff[DATA_W-1]) &&
               (sum[DATA_W-1] != operand_a[DATA_W-1]);
  end

  always_comb begin
    result         = '0;
    flags.carry    = 1'b0;
    flags.overflow = 1'b0;
    case (alu_op_e'(alu_op))
      OP_ADD: begin
        result         = sum[DATA_W-1:0];
        flags.carry    = sum[DATA_W];
        flags.overflow = add_ovf;
      end
      OP_SUB, OP_CMP: begin
        result         = sum[DATA_W-1:0];
        flags.carry    = ~sum[DATA_W];
        flags.overflow = add_ovf;
      end
      OP_AND: result = operand_a & operand_b;
      OP_OR:  result = operand_a | operand_b;
      OP_XOR: result = operand_a ^ operand_b;
      OP_NOT: result = ~operand_a;
      OP_SHL: begin
        result      = {operand_a[DATA_W-2:0], 1'b0};
        flags.carry = operand_a[DATA_W-1];
      end
      OP_SHR: begin
        result      = {1'b0, operand_a[DATA_W-1:1]};
        flags.carry = operand_a[0];
      end
      default: result = '0;
    endcase
    // For CMP the difference is zero exactly when A==B, so one rule covers every opcode.
    flags.zero = (result == '0);
  end

endmodule

// File: rtl/alu.sv
// Registered ALU: one-cycle latency, synchronous active-high reset clearing result and flags.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  output logic [DATA_W-1:0] alu_result,
  output logic              zero_flag,
  output logic              carry_flag,
  output logic              overflow_flag
);

  logic [DATA_W-1:0] next_result;
  alu_flags_t        next_flags;

  alu_core #(
    .DATA_W(DATA_W)
  ) u_core (
    .alu_op   (alu_op),
    .operand_a(operand_a),
    .operand_b(operand_b),
    .result   (next_result),
    .flags    (next_flags)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_result    <= '0;
      zero_flag     <= 1'b0;
      carry_flag    <= 1'b0;
      overflow_flag <= 1'b0;
    end else begin
      alu_result    <= next_result;
      zero_flag     <= next_flags.zero;
      carry_flag    <= next_flags.carry;
      overflow_flag <= next_flags.overflow;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: directed vectors push hand-computed expectations, a monitor pops and compares.
module tb_alu;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] alu_op = 4'h0;
  logic [7:0] operand_a = 8'h00;
  logic [7:0] operand_b = 8'h00;
  logic [7:0] alu_result;
  logic       zero_flag, carry_flag, overflow_flag;

  typedef struct {
    string      name;
    logic [10:0] val;  // {result, z, c, v}
  } exp_t;

  exp_t        exp_q[$];
  int unsigned checks = 0;
  int unsigned failures = 0;
  logic        have_prev = 1'b0;
  logic [10:0] prev_val = '0;

  alu #(.DATA_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .alu_op       (alu_op),
    .operand_a    (operand_a),
    .operand_b    (operand_b),
    .alu_result   (alu_result),
    .zero_flag    (zero_flag),
    .carry_flag   (carry_flag),
    .overflow_flag(overflow_flag)
  );

  always #5 clk = ~clk;

  task automatic issue(input string name, input logic r, input logic [3:0] op,
                       input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] res, input logic z, input logic c,
                       input logic v, input logic glitch);
    exp_t e;
    @(negedge clk);
    rst = r; alu_op = op; operand_a = a; operand_b = b;
    #1;
    if (have_prev) begin
      checks++;
      if ({alu_result, zero_flag, carry_flag, overflow_flag} !== prev_val) begin
        failures++;
        $display("FAIL hold_%s: got %h/%b%b%b, required %h/%b%b%b (outputs moved before edge)",
                 name, alu_result, zero_flag, carry_flag, overflow_flag,
                 prev_val[10:3], prev_val[2], prev_val[1], prev_val[0]);
      end
    end
    e.name = name;
    e.val  = {res, z, c, v};
    exp_q.push_back(e);
    prev_val  = e.val;
    have_prev = 1'b1;
    if (glitch) begin
      rst = 1'b1; #1; rst = 1'b0;
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({alu_result, zero_flag, carry_flag, overflow_flag} !== e.val) begin
          failures++;
          $display("FAIL %s: got res=%h z=%b c=%b v=%b, required res=%h z=%b c=%b v=%b",
                   e.name, alu_result, zero_flag, carry_flag, overflow_flag,
                   e.val[10:3], e.val[2], e.val[1], e.val[0]);
        end
      end
    end
  end

  initial begin : stimulus
    int unsigned waited;
    //     name          rst  op      A      B      res    z     c     v    glitch
    issue("reset",       1, 4'h0, 8'h5A, 8'h33, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    issue("add_basic",   0, 4'h0, 8'h05, 8'h0A, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);
    issue("add_wrap",    0, 4'h0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    issue("add_ovf",     0, 4'h0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0);
    issue("sub_basic",   0, 4'h1, 8'h0A, 8'h05, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0);
    issue("sub_borrow",  0, 4'h1, 8'h05, 8'h0A, 8'hFB, 1'b0, 1'b1, 1'b0, 1'b0);
    issue("sub_ovf",     0, 4'h1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b0);
    issue("and",         0, 4'h2, 8'h0F, 8'h3C, 8'h0C, 1'b0, 1'b0, 1'b0, 1'b0);
    issue("or",          0, 4'h3, 8'h0F, 8'h3C, 8'h3F, 1'b0, 1'b0, 1'b0, 1'b0);
    issue("xor",         0, 4'h4, 8'h0F, 8'h3C, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0);
    issue("not",         0, 4'h5, 8'h55, 8'hFF, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0);
    issue("shl_c0",      0, 4'h6, 8'h0A, 8'hFF, 8'h14, 1'b0, 1'b0, 1'b0, 1'b0);
    issue("shl_c1",      0, 4'h6, 8'h81, 8'h00, 8'h02, 1'b0, 1'b1, 1'b0, 1'b0);
    issue("shr_c0",      0, 4'h7, 8'hA0, 8'hFF, 8'h50, 1'b0, 1'b0, 1'b0, 1'b0);
    issue("shr_z_c1",    0, 4'h7, 8'h01, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    issue("cmp_eq",      0, 4'h8, 8'h12, 8'h12, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    issue("cmp_lt",      0, 4'h8, 8'h12, 8'h34, 8'hDE, 1'b0, 1'b1, 1'b0, 1'b0);
    issue("cmp_ovf",     0, 4'h8, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b0);
    issue("op_1111",     0, 4'hF, 8'hAA, 8'hBB, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    issue("op_1001",     0, 4'h9, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    issue("b2b_add1",    0, 4'h0, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0);
    issue("rst_mid",     1, 4'h0, 8'h10, 8'h20, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    issue("post_rst",    0, 4'h0, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
    issue("rst_glitch",  0, 4'h0, 8'hC0, 8'h40, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
    issue("add_neg_ovf", 0, 4'h0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);

    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
